gpu_bg_block_buffer: RTL
========================

Name: gpu_bg_block_buffer

Overview:
- Parametrised background-block write-back buffer for the GPU backend; generalises the fixed 2-pixel/16-pixel BG cache line.
- Holds one resident VRAM block of BLOCK_PIX 16-bit pixels with a per-pixel written mask.
- Accepts LANES pixels per clock from the pixel pipeline and supplies resident BG pixels for blending.
- On a block change it autonomously saves the dirty block and optionally loads the next one over req/ack handshakes, stalling the pipeline meanwhile.

Parameters:
LANES, 2, pixels written per clock (1, 2 or 4); power of two.
BLOCK_PIX, 16, pixels per block; power of two, multiple of LANES, at most 64.
ADR_W, 15, block address width (Y concatenated with X block index).
SLOT_W, log2(BLOCK_PIX/LANES), derived slot index width; minimum 1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
i_nrst  in  1  reset; asynchronous, active-low.
i_wrValid  in  1  pipeline presents a write group.
i_wrBlockAdr  in  ADR_W  target block of the group.
i_wrSlot  in  SLOT_W  lane-group index inside the block.
i_wrLaneEn  in  LANES  per-lane write enable.
i_wrData  in  16*LANES  pixels; lane k is bits [16k+15:16k].
i_needBG  in  1  the primitive blends or mask-tests, so BG content is required.
i_flush  in  1  level request to write back and empty the buffer.
o_stall  out  1  combinational; the group is not accepted this cycle.
o_bgPix  out  16*LANES  resident pixels at i_wrSlot; combinational.
o_flushDone  out  1  one-cycle pulse when a flush completes.
o_saveReq  out  1  save request.
o_saveAdr  out  ADR_W  block to save.
o_saveData  out  16*BLOCK_PIX  resident block data.
o_saveMask  out  BLOCK_PIX  written-pixel mask; pixel i is bit i.
i_saveAck  in  1  save accepted.
o_loadReq  out  1  load request.
o_loadAdr  out  ADR_W  block to load.
i_loadAck  in  1  load data valid this cycle.
i_loadData  in  16*BLOCK_PIX  loaded block data.

Behaviour:
- Registers: state, resAdr, buf, mask, bgLoaded, pendAdr, retState, both req flags.
- States: EMPTY, RESIDENT, SAVE, LOAD.
- Reset values: state=EMPTY, mask=0, bgLoaded=0, o_saveReq=0, o_loadReq=0, o_flushDone=0. buf content is don't-care.
- hit = (state==RESIDENT) && (i_wrBlockAdr==resAdr). o_stall = i_wrValid && !(hit && (bgLoaded || !i_needBG)).
- Accept = i_wrValid && !o_stall.
  - For each lane k with i_wrLaneEn[k]=1: buf pixel (i_wrSlot*LANES+k) is updated and its mask bit is set, at the next edge.
  - An accepted group with i_wrLaneEn=0 is a no-op.
- o_bgPix reads buf. It reflects writes from earlier cycles only; there is no same-cycle bypass.
- Miss handling (i_wrValid=1 && o_stall=1, evaluated in EMPTY or RESIDENT):
  - Block change with mask!=0: latch pendAdr=i_wrBlockAdr, enter SAVE.
  - Block change with mask==0 (including EMPTY):
    - if i_needBG: enter LOAD with o_loadAdr=pendAdr;
    - else: resAdr=pendAdr, mask=0, bgLoaded=0, stay or enter RESIDENT. The group is accepted one cycle later.
  - Hit with i_needBG && !bgLoaded: enter LOAD on resAdr. This is a merge load; no save occurs.
- SAVE:
  - o_saveReq=1, o_saveAdr=resAdr. o_saveData and o_saveMask stay stable because writes are stalled.
  - On i_saveAck: req drops next cycle and mask clears.
  - Then: if retState is flush, go to EMPTY and pulse o_flushDone. Otherwise allocate pendAdr and enter LOAD if i_needBG, else RESIDENT.
- LOAD:
  - o_loadReq=1 until i_loadAck.
  - On ack, per pixel: buf = mask bit ? buf : i_loadData. Written pixels survive the merge.
  - Also on ack: bgLoaded=1, state becomes RESIDENT.
- Acks:
  - Acks may arrive in the same cycle the request rises, earliest one cycle after state entry.
  - An ack with its req low is ignored.
  - Each req is a level that falls exactly one cycle after its ack.
- Flush:
  - Serviced only in EMPTY or RESIDENT with i_wrValid=0.
  - mask!=0: enter SAVE with retState=flush.
  - Otherwise go to EMPTY, pulse o_flushDone next cycle, clear bgLoaded.
  - If i_flush and i_wrValid are both high, the write wins; the flush waits.
- Latencies:
  - Hit: 0-cycle stall.
  - Miss with no save and no load: 1 stall cycle.
  - Otherwise 1 + save handshake + load handshake cycles.
- An asynchronous reset mid-handshake drops both reqs immediately; the memory side discards any outstanding transfer.

Test Plan:
- Reset, then write adr=0x0010, slot=3, lanes=2'b11, data={0x7FFF,0x1234}, needBG=0 -> 1 stall cycle, accept; next cycle buf pixels 6,7=0x1234,0x7FFF and mask=0x00C0; no req.
- Resident dirty 0x0010, write adr=0x0011, needBG=0 -> o_saveReq with adr 0x0010 and mask 0x00C0. With ack 3 cycles later, req falls next cycle and the write is accepted 2 cycles after ack.
- Clean EMPTY, write adr=0x0020 with needBG=1 -> o_loadReq adr 0x0020. On ack with data all 0x5555, o_bgPix reads 0x5555 at any slot and the group is then accepted.
- Resident 0x0030 (bgLoaded=0, pixel 0 written 0x0001), write needBG=1 to same block -> merge LOAD; load data all 0xAAAA gives pixel 0=0x0001 and others=0xAAAA, with no save.
- i_flush with mask=0x0003 -> save of the resident block; o_flushDone pulses once after ack; state is EMPTY. A second flush with mask=0 pulses o_flushDone with no save.
- Assert i_nrst=0 during SAVE with req high -> req low asynchronously, mask=0; after release, o_stall=0 while i_wrValid=0.

Source files
------------

// File: rtl/gpu_bg_block_buffer.sv
// gpu_bg_block_buffer: one resident VRAM block with a written-pixel mask,
// autonomously saved and (re)loaded over req/ack handshakes on block change.
module gpu_bg_block_buffer #(
    parameter int LANES     = 2,
    parameter int BLOCK_PIX = 16,
    parameter int ADR_W     = 15,
    parameter int SLOT_W    = (BLOCK_PIX / LANES > 1) ? $clog2(BLOCK_PIX / LANES) : 1
) (
    input  logic                   clk,
    input  logic                   i_nrst,
    input  logic                   i_wrValid,
    input  logic [ADR_W-1:0]       i_wrBlockAdr,
    input  logic [SLOT_W-1:0]      i_wrSlot,
    input  logic [LANES-1:0]       i_wrLaneEn,
    input  logic [16*LANES-1:0]    i_wrData,
    input  logic                   i_needBG,
    input  logic                   i_flush,
    output logic                   o_stall,
    output logic [16*LANES-1:0]    o_bgPix,
    output logic                   o_flushDone,
    output logic                   o_saveReq,
    output logic [ADR_W-1:0]       o_saveAdr,
    output logic [16*BLOCK_PIX-1:0] o_saveData,
    output logic [BLOCK_PIX-1:0]   o_saveMask,
    input  logic                   i_saveAck,
    output logic                   o_loadReq,
    output logic [ADR_W-1:0]       o_loadAdr,
    input  logic                   i_loadAck,
    input  logic [16*BLOCK_PIX-1:0] i_loadData
);
    typedef enum logic [1:0] {EMPTY, RESIDENT, SAVE, LOAD} stateT;

    stateT                   state;
    logic [ADR_W-1:0]        resAdr, pendAdr;
    logic [16*BLOCK_PIX-1:0] pixBuf;
    logic [BLOCK_PIX-1:0]    mask, wrMask;
    logic                    bgLoaded, retFlush, hit, accept, loadTake;
    logic [16*LANES-1:0]     slotView [2**SLOT_W];

    assign hit        = (state == RESIDENT) && (i_wrBlockAdr == resAdr);
    assign o_stall    = i_wrValid && !(hit && (bgLoaded || !i_needBG));
    assign accept     = i_wrValid && !o_stall;
    assign loadTake   = (state == LOAD) && o_loadReq && i_loadAck;
    assign o_saveAdr  = resAdr;
    assign o_loadAdr  = resAdr;
    assign o_saveData = pixBuf;
    assign o_saveMask = mask;
    assign o_bgPix    = slotView[i_wrSlot];

    for (genvar p = 0; p < BLOCK_PIX; p++) begin : g_wr
        assign wrMask[p] = accept && i_wrLaneEn[p % LANES] && (i_wrSlot == SLOT_W'(p / LANES));
    end

    for (genvar s = 0; s < 2**SLOT_W; s++) begin : g_slot
        assign slotView[s] = pixBuf[(16*LANES*s) % (16*BLOCK_PIX) +: 16*LANES];
    end

    // Written pixels take priority over loaded data so a merge load never clobbers them.
    always_ff @(posedge clk)
        for (int p = 0; p < BLOCK_PIX; p++)
            if (wrMask[p]) pixBuf[16*p +: 16] <= i_wrData[16*(p % LANES) +: 16];
            else if (loadTake && !mask[p]) pixBuf[16*p +: 16] <= i_loadData[16*p +: 16];

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state       <= EMPTY;
            resAdr      <= '0;
            pendAdr     <= '0;
            mask        <= '0;
            bgLoaded    <= 1'b0;
            retFlush    <= 1'b0;
            o_saveReq   <= 1'b0;
            o_loadReq   <= 1'b0;
            o_flushDone <= 1'b0;
        end else begin
            o_flushDone <= 1'b0;
            case (state)
                EMPTY, RESIDENT:
                    if (accept) mask <= mask | wrMask;
                    else if (i_wrValid) begin
                        if (!hit && mask != '0) begin
                            pendAdr   <= i_wrBlockAdr;
                            retFlush  <= 1'b0;
                            o_saveReq <= 1'b1;
                            state     <= SAVE;
                        end else if (!hit) begin
                            resAdr    <= i_wrBlockAdr;
                            pendAdr   <= i_wrBlockAdr;
                            mask      <= '0;
                            bgLoaded  <= 1'b0;
                            o_loadReq <= i_needBG;
                            state     <= i_needBG ? LOAD : RESIDENT;
                        end else begin
                            o_loadReq <= 1'b1;
                            state     <= LOAD;
                        end
                    end else if (i_flush) begin
                        if (mask != '0) begin
                            retFlush  <= 1'b1;
                            o_saveReq <= 1'b1;
                            state     <= SAVE;
                        end else begin
                            o_flushDone <= 1'b1;
                            bgLoaded    <= 1'b0;
                            state       <= EMPTY;
                        end
                    end
                // Req high: wait for ack. Req low: the save is done, move on.
                SAVE:
                    if (o_saveReq) begin
                        if (i_saveAck) begin
                            o_saveReq <= 1'b0;
                            mask      <= '0;
                        end
                    end else if (retFlush) begin
                        o_flushDone <= 1'b1;
                        bgLoaded    <= 1'b0;
                        state       <= EMPTY;
                    end else begin
                        resAdr    <= pendAdr;
                        bgLoaded  <= 1'b0;
                        o_loadReq <= i_needBG;
                        state     <= i_needBG ? LOAD : RESIDENT;
                    end
                LOAD:
                    if (loadTake) begin
                        o_loadReq <= 1'b0;
                        bgLoaded  <= 1'b1;
                        state     <= RESIDENT;
                    end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
